seg_scan_drv: RTL and testbench

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

---
 rtl/seg_scan_drv.sv | 151 +++++++++++++++
 tb/tb_seg_scan_drv.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_drv.sv
// Multiplexed 7-segment scanner: DIGITS BCD magnitude digits plus one sign position.
// Define SEG_SCAN_LZB_EN to blank leading zeros of the magnitude (units digit always shown).
module seg_scan_drv #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [3:0]            bcd_sgn,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS:0]       dig_en,
    output logic                  frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int PW = (DIGITS + 1 > 2) ? $clog2(DIGITS + 1) : 1;

    localparam logic [0:0] S_SCAN  = 1'b0;
    localparam logic [0:0] S_BLANK = 1'b1;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [CW-1:0]       cnt;
    logic                tick;
    logic [0:0]          state;
    logic [PW-1:0]       pos;
    logic                pos_last;
    logic [4*DIGITS-1:0] sh_bcd;
    logic [3:0]          sh_sgn;
    logic [3:0]          code;
    logic                lzb;
    logic [6:0]          seg_dec;

    assign tick     = (cnt == CW'(PRESCALE - 1));
    assign pos_last = (pos == PW'(DIGITS));

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            4'hA:    s = 7'h3F;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Prescaler free-runs regardless of FSM state or load
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_bcd <= '1;
            sh_sgn <= 4'hF;
        end else if (load) begin
            sh_bcd <= bcd;
            sh_sgn <= bcd_sgn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SCAN;
            pos   <= '0;
        end else begin
            case (state)
                S_SCAN: begin
                    if (tick) begin
                        state <= S_BLANK;
                    end
                end
                default: begin
                    state <= S_SCAN;
                    pos   <= pos_last ? '0 : pos + PW'(1);
                end
            endcase
        end
    end

    always_comb begin
        code = sh_sgn;
        for (int k = 0; k < DIGITS; k++) begin
            if (pos == PW'(k)) begin
                code = sh_bcd[4*k +: 4];
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] lz_mask;

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        logic zabove;
        zabove  = 1'b1;
        lz_mask = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zabove     = zabove && (sh_bcd[4*k +: 4] == 4'd0);
            lz_mask[k] = zabove;
        end
    end

    always_comb begin
        lzb = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (pos == PW'(k)) begin
                lzb = lz_mask[k];
            end
        end
    end
`else
    assign lzb = 1'b0;
`endif

    assign seg_dec = lzb ? SEG_OFF : decode(code);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dig_en     <= '1;
            frame_done <= 1'b0;
        end else if (state == S_SCAN) begin
            seg        <= seg_dec;
            dig_en     <= ~((DIGITS+1)'(1) << pos);
            frame_done <= 1'b0;
        end else begin
            seg        <= SEG_OFF;
            dig_en     <= '1;
            frame_done <= pos_last;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv with DIGITS=2, PRESCALE=4.
// Expected outputs are queued per edge from a cycle-indexed reference model.
module tb_seg_scan_drv;

    localparam int D = 2;
    localparam int P = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic [D:0] en;
        logic       fd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4*D-1:0] bcd = '0;
    logic [3:0]     bcd_sgn = 4'hF;
    logic           load = 1'b0;
    logic [6:0]     seg;
    logic [D:0]     dig_en;
    logic           frame_done;

    int n_vec = 0;
    int n_bad = 0;
    int k = 0;
    int fd_seen = 0;
    logic [4*D-1:0] m_bcd = '1;
    logic [3:0]     m_sgn = 4'hF;
    exp_t q[$];

    logic [6:0] tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F,
                               7'h7F, 7'h7F, 7'h7F, 7'h7F};

    seg_scan_drv #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .bcd(bcd), .bcd_sgn(bcd_sgn),
        .load(load), .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%h want=%h", tag, k, got, want);
        end
    endtask

    function automatic logic [6:0] show(input int p);
        logic [3:0] c;
        if (p == D) return tbl[m_sgn];
        c = m_bcd[4*p +: 4];
`ifdef SEG_SCAN_LZB_EN
        if (p >= 1) begin
            logic z;
            z = 1'b1;
            for (int j = p; j < D; j++) z = z && (m_bcd[4*j +: 4] == 4'd0);
            if (z) return 7'h7F;
        end
`endif
        return tbl[c];
    endfunction

    // Slot k (edges since reset release): BLANK every P edges after the first
    function automatic exp_t model(input int kk);
        exp_t e;
        int p;
        if (kk > 0 && kk % P == 0) begin
            e.seg = 7'h7F;
            e.en  = '1;
            e.fd  = ((kk / P - 1) % (D + 1)) == D;
        end else begin
            p     = (kk / P) % (D + 1);
            e.seg = show(p);
            e.en  = ~((D+1)'(1) << p);
            e.fd  = 1'b0;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic ld,
                        input logic [4*D-1:0] b, input logic [3:0] s);
        exp_t e;
        rst = r; load = ld; bcd = b; bcd_sgn = s;
        if (r) begin
            e = '{seg: 7'h7F, en: '1, fd: 1'b0};
        end else begin
            e = model(k);
        end
        q.push_back(e);
        if (r) begin
            m_bcd = '1;
            m_sgn = 4'hF;
        end else if (ld) begin
            m_bcd = b;
            m_sgn = s;
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("seg", 16'(seg), 16'(e.seg));
        chk("dig_en", 16'(dig_en), 16'(e.en));
        chk("frame_done", 16'(frame_done), 16'(e.fd));
        if (frame_done === 1'b1) fd_seen++;
        k = r ? 0 : k + 1;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, bcd, bcd_sgn);
    endtask

    initial begin
        step(1'b1, 1'b0, '0, 4'hF);
        step(1'b1, 1'b0, '0, 4'hF);
        idle(12);

        step(1'b0, 1'b1, 8'h37, 4'hA);
        fd_seen = 0;
        idle(24);
        chk("fd_per_24", 16'(fd_seen), 16'd2);

        step(1'b0, 1'b1, 8'h05, 4'hF);
        idle(13);

        while (!(k > 0 && k % P == 0)) idle(1);
        step(1'b0, 1'b1, 8'h99, 4'hF);
        idle(13);

        step(1'b0, 1'b1, 8'hC1, 4'hA);
        idle(13);

        while (k % (P * (D + 1)) != P + 1) idle(1);
        step(1'b1, 1'b1, 8'h55, 4'h3);
        idle(14);

        step(1'b0, 1'b1, 8'h20, 4'hF);
        idle(13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
